reg_file_checker: RTL and testbench
===================================

Name: reg_file_checker

Overview:
Synthesizable self-checking monitor that generalises the per-test register-file compare used by the instruction tests.
- Holds a programmable table of expected register values.
- Lets the core run for a fixed cycle budget, or until it halts early.
- Scans the core's register file through a synchronous read port, one register per cycle.
- Reports pass/fail, mismatch count and first-failure details.
- Sits beside RISC_V_Core in on-chip or FPGA self-test wrappers, so no simulator-only hierarchical references are needed.

Parameters:
DATA_WIDTH, 32, register width
NUM_REGS, 32, registers checked (indices 0..NUM_REGS-1)
IDX_BITS, 5, index width; must satisfy 2^IDX_BITS >= NUM_REGS
RUN_CYCLES, 100, cycles the core runs before the scan starts
CNT_BITS, 16, width of the run counter and mismatch counter

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse; accepted only in IDLE
halt  in  1  core finished early; honoured only in RUN
exp_we  in  1  expected-table write enable; honoured only in IDLE
exp_idx  in  IDX_BITS  expected-table write index
exp_data  in  DATA_WIDTH  expected value
rf_rd_idx  out  IDX_BITS  register-file read index
rf_rd_data  in  DATA_WIDTH  register data; valid the cycle after rf_rd_idx is presented
busy  out  1  high in RUN and SCAN
done  out  1  one-cycle pulse when the result is final
pass  out  1  result; held until the next accepted start
mismatch_count  out  CNT_BITS  number of failing registers, saturating
fail_valid  out  1  at least one mismatch recorded
first_fail_idx  out  IDX_BITS  index of the lowest failing register
first_fail_exp  out  DATA_WIDTH  expected value at first failure
first_fail_act  out  DATA_WIDTH  actual value at first failure

Behaviour:
- Reset (asynchronous assert, synchronous release): FSM goes to IDLE.
  - Every output resets to 0.
  - The expected table resets to all zero.
  - A reset mid-RUN or mid-SCAN aborts with no done pulse.
- FSM states: IDLE, RUN, SCAN, DONE.
- IDLE:
  - exp_we writes exp_data into table[exp_idx]. Writes with exp_idx >= NUM_REGS are dropped.
  - start moves to RUN: loads the run counter with RUN_CYCLES and clears pass, mismatch_count, fail_valid and all first_fail_*.
  - A write and a start in the same cycle: the write is performed and start is accepted.
- RUN:
  - Counter decrements each cycle.
  - Moves to SCAN when the counter is 0 or halt=1. With RUN_CYCLES=0, RUN lasts exactly 1 cycle.
  - exp_we and start are ignored.
- SCAN (pipelined, 1-cycle read latency):
  - Scan cycle k drives rf_rd_idx=k for k<NUM_REGS.
  - Scan cycle k compares table[k-1] with rf_rd_data for k>=1.
  - Scan lasts NUM_REGS+1 cycles, then moves to DONE.
  - rf_rd_idx holds NUM_REGS-1 on the final cycle and is 0 outside SCAN.
- On a mismatch:
  - mismatch_count increments, saturating at 2^CNT_BITS-1.
  - If fail_valid was 0, capture index, expected and actual values, then set fail_valid.
- DONE: lasts 1 cycle.
  - done=1 and pass=(mismatch_count==0), registered in that cycle.
  - Then returns to IDLE.
  - Results hold until the next accepted start.
- busy is high in RUN and SCAN only. Total latency from start to done is run-length + NUM_REGS + 2 cycles.
- Register 0 is compared like any other register.

Optional Feature:
REG_CHECK_MASK_EN
- Defined: adds input exp_mask (DATA_WIDTH), written alongside exp_data into a parallel mask table that resets to all ones.
  - Compare rule: ((rf_rd_data ^ table[k]) & mask[k]) == 0.
  - A mask of 0 makes that register don't-care.
  - first_fail_act reports the unmasked actual value.
- Undefined: no exp_mask port and no mask storage; compare is exact equality.

Test Plan:
- Reset, then load the sh_lhu expectations: idx11=0x13, idx12..17=0x8000..0x8005, all others 0. Register model matches, start -> done 1 cycle after 134 cycles of busy; pass=1, mismatch_count=0, fail_valid=0.
- Same table, model idx14=0x8012 and idx16=0 -> pass=0, mismatch_count=2, first_fail_idx=14, first_fail_exp=0x8002, first_fail_act=0x8012.
- halt asserted 5 cycles after start with RUN_CYCLES=100 -> rf_rd_idx=0 on the next cycle; done arrives 5+34 cycles after start.
- exp_we (idx 3, 0xDEAD) and start issued during RUN or SCAN -> both ignored; table[3] unchanged; one done pulse only.
- reset deasserted-to-asserted mid-SCAN at idx 10 -> all outputs 0 immediately, no done pulse, table reads zero; a later start with a zero register model gives pass=1.
- With REG_CHECK_MASK_EN: idx5 exp=0x1234 mask=0xFF00, actual 0x12FF -> pass=1; mask=0xFFFF -> pass=0, first_fail_idx=5.

Source files
------------

// File: rtl/reg_file_checker.sv
// Self-test monitor: runs the core for a cycle budget, scans its register file and compares against a table.
// Optional REG_CHECK_MASK_EN adds a per-register compare mask (exp_mask input and mask table).
module reg_file_checker #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  parameter int IDX_BITS   = 5,
  parameter int RUN_CYCLES = 100,
  parameter int CNT_BITS   = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  halt,
  input  logic                  exp_we,
  input  logic [IDX_BITS-1:0]   exp_idx,
  input  logic [DATA_WIDTH-1:0] exp_data,
`ifdef REG_CHECK_MASK_EN
  input  logic [DATA_WIDTH-1:0] exp_mask,
`endif
  output logic [IDX_BITS-1:0]   rf_rd_idx,
  input  logic [DATA_WIDTH-1:0] rf_rd_data,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [CNT_BITS-1:0]   mismatch_count,
  output logic                  fail_valid,
  output logic [IDX_BITS-1:0]   first_fail_idx,
  output logic [DATA_WIDTH-1:0] first_fail_exp,
  output logic [DATA_WIDTH-1:0] first_fail_act
);

  localparam int SCAN_BITS = IDX_BITS + 1;
  localparam logic [SCAN_BITS-1:0] LAST_SCAN = SCAN_BITS'(NUM_REGS);
  localparam logic [IDX_BITS-1:0]  LAST_IDX  = IDX_BITS'(NUM_REGS - 1);
  localparam logic [CNT_BITS-1:0]  RUN_LOAD  = CNT_BITS'(RUN_CYCLES);
  localparam logic [CNT_BITS-1:0]  CNT_MAX   = {CNT_BITS{1'b1}};

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, SCAN = 2'd2, DONE = 2'd3} state_t;

  state_t                state_r, state_n;
  logic [CNT_BITS-1:0]   run_cnt_r, run_cnt_n;
  logic [SCAN_BITS-1:0]  scan_cnt_r, scan_cnt_n;
  logic [IDX_BITS-1:0]   rd_idx_r, rd_idx_n;
  logic                  busy_r, busy_n;
  logic                  done_r, done_n;
  logic                  pass_r, pass_n;
  logic [CNT_BITS-1:0]   mis_r, mis_n;
  logic                  fv_r, fv_n;
  logic [IDX_BITS-1:0]   ffi_r, ffi_n;
  logic [DATA_WIDTH-1:0] ffe_r, ffe_n;
  logic [DATA_WIDTH-1:0] ffa_r, ffa_n;

  logic [DATA_WIDTH-1:0] exp_tbl_r [NUM_REGS];
  logic                  tbl_we_s;
  logic [IDX_BITS-1:0]   cmp_idx_s;
  logic [DATA_WIDTH-1:0] cmp_exp_s;
  logic [DATA_WIDTH-1:0] cmp_mask_s;

`ifdef REG_CHECK_MASK_EN
  logic [DATA_WIDTH-1:0] mask_tbl_r [NUM_REGS];
`endif

  function automatic logic word_differs(input logic [DATA_WIDTH-1:0] act,
                                        input logic [DATA_WIDTH-1:0] expv,
                                        input logic [DATA_WIDTH-1:0] mask);
    return |((act ^ expv) & mask);
  endfunction

  // Out-of-range indices are dropped; scan cycle k compares the entry read back for index k-1.
  assign tbl_we_s  = (state_r == IDLE) && exp_we && ({1'b0, exp_idx} < LAST_SCAN);
  assign cmp_idx_s = IDX_BITS'(scan_cnt_r - SCAN_BITS'(1));
  assign cmp_exp_s = exp_tbl_r[cmp_idx_s];
`ifdef REG_CHECK_MASK_EN
  assign cmp_mask_s = mask_tbl_r[cmp_idx_s];
`else
  assign cmp_mask_s = {DATA_WIDTH{1'b1}};
`endif

  // Next-state and next-result computation.
  always_comb begin
    state_n    = state_r;
    run_cnt_n  = run_cnt_r;
    scan_cnt_n = scan_cnt_r;
    pass_n     = pass_r;
    mis_n      = mis_r;
    fv_n       = fv_r;
    ffi_n      = ffi_r;
    ffe_n      = ffe_r;
    ffa_n      = ffa_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_n   = RUN;
          run_cnt_n = RUN_LOAD;
          pass_n    = 1'b0;
          mis_n     = {CNT_BITS{1'b0}};
          fv_n      = 1'b0;
          ffi_n     = {IDX_BITS{1'b0}};
          ffe_n     = {DATA_WIDTH{1'b0}};
          ffa_n     = {DATA_WIDTH{1'b0}};
        end else begin
          state_n = IDLE;
        end
      end
      RUN: begin
        if ((run_cnt_r == {CNT_BITS{1'b0}}) || halt) begin
          state_n    = SCAN;
          scan_cnt_n = {SCAN_BITS{1'b0}};
        end else begin
          run_cnt_n = run_cnt_r - CNT_BITS'(1);
        end
      end
      SCAN: begin
        if ((scan_cnt_r != {SCAN_BITS{1'b0}}) && word_differs(rf_rd_data, cmp_exp_s, cmp_mask_s)) begin
          if (mis_r != CNT_MAX) begin
            mis_n = mis_r + CNT_BITS'(1);
          end else begin
            mis_n = mis_r;
          end
          if (!fv_r) begin
            fv_n  = 1'b1;
            ffi_n = cmp_idx_s;
            ffe_n = cmp_exp_s;
            ffa_n = rf_rd_data;
          end else begin
            fv_n = fv_r;
          end
        end else begin
          mis_n = mis_r;
        end
        if (scan_cnt_r == LAST_SCAN) begin
          state_n = DONE;
          pass_n  = (mis_n == {CNT_BITS{1'b0}});
        end else begin
          scan_cnt_n = scan_cnt_r + SCAN_BITS'(1);
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    busy_n = (state_n == RUN) || (state_n == SCAN);
    done_n = (state_n == DONE);
    if (state_n != SCAN) begin
      rd_idx_n = {IDX_BITS{1'b0}};
    end else if (scan_cnt_n >= {1'b0, LAST_IDX}) begin
      rd_idx_n = LAST_IDX;
    end else begin
      rd_idx_n = scan_cnt_n[IDX_BITS-1:0];
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r    <= IDLE;
      run_cnt_r  <= {CNT_BITS{1'b0}};
      scan_cnt_r <= {SCAN_BITS{1'b0}};
      rd_idx_r   <= {IDX_BITS{1'b0}};
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      pass_r     <= 1'b0;
      mis_r      <= {CNT_BITS{1'b0}};
      fv_r       <= 1'b0;
      ffi_r      <= {IDX_BITS{1'b0}};
      ffe_r      <= {DATA_WIDTH{1'b0}};
      ffa_r      <= {DATA_WIDTH{1'b0}};
    end else begin
      state_r    <= state_n;
      run_cnt_r  <= run_cnt_n;
      scan_cnt_r <= scan_cnt_n;
      rd_idx_r   <= rd_idx_n;
      busy_r     <= busy_n;
      done_r     <= done_n;
      pass_r     <= pass_n;
      mis_r      <= mis_n;
      fv_r       <= fv_n;
      ffi_r      <= ffi_n;
      ffe_r      <= ffe_n;
      ffa_r      <= ffa_n;
    end
  end

  // Expected-value table (and mask table when enabled).
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        exp_tbl_r[i] <= {DATA_WIDTH{1'b0}};
`ifdef REG_CHECK_MASK_EN
        mask_tbl_r[i] <= {DATA_WIDTH{1'b1}};
`endif
      end
    end else if (tbl_we_s) begin
      exp_tbl_r[exp_idx] <= exp_data;
`ifdef REG_CHECK_MASK_EN
      mask_tbl_r[exp_idx] <= exp_mask;
`endif
    end
  end

  assign rf_rd_idx      = rd_idx_r;
  assign busy           = busy_r;
  assign done           = done_r;
  assign pass           = pass_r;
  assign mismatch_count = mis_r;
  assign fail_valid     = fv_r;
  assign first_fail_idx = ffi_r;
  assign first_fail_exp = ffe_r;
  assign first_fail_act = ffa_r;

endmodule

// File: tb/tb_reg_file_checker.sv
// Randomised self-checking bench for reg_file_checker with a behavioural register-file and result model.
module tb_reg_file_checker;

  localparam int DW = 32;
  localparam int NR = 32;
  localparam int IB = 5;
  localparam int RC = 100;
  localparam int CB = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          halt = 1'b0;
  logic          exp_we = 1'b0;
  logic [IB-1:0] exp_idx = '0;
  logic [DW-1:0] exp_data = '0;
`ifdef REG_CHECK_MASK_EN
  logic [DW-1:0] exp_mask = '0;
`endif
  logic [IB-1:0] rf_rd_idx;
  logic [DW-1:0] rf_rd_data;
  logic          busy, done, pass, fail_valid;
  logic [CB-1:0] mismatch_count;
  logic [IB-1:0] first_fail_idx;
  logic [DW-1:0] first_fail_exp, first_fail_act;

  reg_file_checker dut (
    .clock(clock), .reset(reset), .start(start), .halt(halt),
    .exp_we(exp_we), .exp_idx(exp_idx), .exp_data(exp_data),
`ifdef REG_CHECK_MASK_EN
    .exp_mask(exp_mask),
`endif
    .rf_rd_idx(rf_rd_idx), .rf_rd_data(rf_rd_data),
    .busy(busy), .done(done), .pass(pass), .mismatch_count(mismatch_count),
    .fail_valid(fail_valid), .first_fail_idx(first_fail_idx),
    .first_fail_exp(first_fail_exp), .first_fail_act(first_fail_act)
  );

  always #5 clock = ~clock;

  logic [DW-1:0] exp_tbl  [NR];
  logic [DW-1:0] mask_tbl [NR];
  logic [DW-1:0] rf_model [NR];

  // Synchronous-read register file of the core being checked.
  always @(posedge clock) rf_rd_data <= rf_model[rf_rd_idx];

  int n_checks = 0;
  int n_fail = 0;

  // Observations from one run.
  int            o_done_cycle, o_busy, o_dones;
  logic          o_pass, o_pass_late, o_fv;
  logic [CB-1:0] o_mis;
  logic [IB-1:0] o_ffi;
  logic [DW-1:0] o_ffe, o_ffa;
  logic [IB-1:0] idx_log [600];

  // Model predictions.
  logic          e_pass, e_fv;
  int            e_mis, e_ffi;
  logic [DW-1:0] e_ffe, e_ffa;

  task automatic clear_model;
    for (int i = 0; i < NR; i++) begin
      exp_tbl[i]  = 32'h0;
      mask_tbl[i] = 32'hFFFF_FFFF;
      rf_model[i] = 32'h0;
    end
  endtask

  task automatic predict;
    e_mis = 0; e_fv = 1'b0; e_ffi = 0; e_ffe = 32'h0; e_ffa = 32'h0;
    for (int i = 0; i < NR; i++) begin
      if (((rf_model[i] ^ exp_tbl[i]) & mask_tbl[i]) != 32'h0) begin
        if (!e_fv) begin
          e_ffi = i; e_ffe = exp_tbl[i]; e_ffa = rf_model[i];
        end
        e_fv = 1'b1;
        e_mis++;
      end
    end
    e_pass = (e_mis == 0);
  endtask

  function automatic int expected_latency(input int halt_at);
    int run_len;
    run_len = (halt_at >= 1 && halt_at <= RC + 1) ? halt_at : RC + 1;
    return run_len + NR + 2;
  endfunction

  task automatic load_table;
    for (int i = 0; i < NR; i++) begin
      @(negedge clock);
      exp_we = 1'b1; exp_idx = IB'(i); exp_data = exp_tbl[i];
`ifdef REG_CHECK_MASK_EN
      exp_mask = mask_tbl[i];
`endif
    end
    @(negedge clock);
    exp_we = 1'b0;
  endtask

  // Start a run, optionally with a same-cycle write to index 20, a halt and an injected write+start.
  task automatic run_once(input int halt_at, input int inject_at, input logic wr_at_start, input logic [DW-1:0] wr_data);
    int c, post;
    o_done_cycle = -1; o_busy = 0; o_dones = 0; post = 0;
    @(negedge clock);
    start = 1'b1;
    if (wr_at_start) begin
      exp_we = 1'b1; exp_idx = 5'd20; exp_data = wr_data;
    end
    @(negedge clock);
    start = 1'b0; exp_we = 1'b0;
    c = 1;
    while (c < 600 && post < 4) begin
      halt = (c == halt_at);
      if (c == inject_at) begin
        exp_we = 1'b1; exp_idx = 5'd3; exp_data = 32'hDEAD; start = 1'b1;
      end else begin
        exp_we = 1'b0; start = 1'b0;
      end
      if (busy) o_busy++;
      idx_log[c] = rf_rd_idx;
      if (done) begin
        o_dones++;
        if (o_done_cycle < 0) begin
          o_done_cycle = c; o_pass = pass; o_mis = mismatch_count; o_fv = fail_valid;
          o_ffi = first_fail_idx; o_ffe = first_fail_exp; o_ffa = first_fail_act;
        end
      end
      if (o_done_cycle >= 0) post++;
      o_pass_late = pass;
      @(negedge clock);
      c++;
    end
    halt = 1'b0; exp_we = 1'b0; start = 1'b0;
  endtask

  task automatic test_reset;
    clear_model();
    reset = 1'b0;
    repeat (2) @(negedge clock);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_checks++; if (pass !== 1'b0) begin n_fail++; $display("FAIL reset_pass: got %b expected 0", pass); end
    n_checks++; if (mismatch_count !== 16'h0) begin n_fail++; $display("FAIL reset_mis: got %h expected 0", mismatch_count); end
    n_checks++; if (fail_valid !== 1'b0) begin n_fail++; $display("FAIL reset_fv: got %b expected 0", fail_valid); end
    n_checks++; if ({first_fail_idx, first_fail_exp, first_fail_act} !== 69'h0) begin
      n_fail++; $display("FAIL reset_first: got %h/%h/%h expected zeros", first_fail_idx, first_fail_exp, first_fail_act); end
    n_checks++; if (rf_rd_idx !== 5'd0) begin n_fail++; $display("FAIL reset_rdidx: got %0d expected 0", rf_rd_idx); end
    reset = 1'b1;
    repeat (2) @(negedge clock);
    n_checks++; if ({busy, done, pass} !== 3'b000) begin n_fail++; $display("FAIL idle_flags: got %b expected 000", {busy, done, pass}); end
  endtask

  task automatic set_sh_lhu;
    clear_model();
    exp_tbl[11] = 32'h13;
    for (int j = 0; j < 6; j++) exp_tbl[12 + j] = 32'h8000 + j;
    for (int i = 0; i < NR; i++) rf_model[i] = exp_tbl[i];
  endtask

  task automatic test_sh_lhu_pass;
    set_sh_lhu();
    load_table();
    run_once(0, -1, 1'b0, 32'h0);
    n_checks++; if (o_done_cycle != 135) begin n_fail++; $display("FAIL pass_latency: got %0d expected 135", o_done_cycle); end
    n_checks++; if (o_busy != 134) begin n_fail++; $display("FAIL pass_busy_cycles: got %0d expected 134", o_busy); end
    n_checks++; if (o_dones != 1) begin n_fail++; $display("FAIL pass_done_pulses: got %0d expected 1", o_dones); end
    n_checks++; if ({o_pass, o_mis, o_fv} !== {1'b1, 16'h0, 1'b0}) begin
      n_fail++; $display("FAIL pass_result: got pass=%b mis=%0d fv=%b expected 1/0/0", o_pass, o_mis, o_fv); end
    n_checks++; if (o_pass_late !== 1'b1) begin n_fail++; $display("FAIL pass_held: got %b expected 1", o_pass_late); end
  endtask

  task automatic test_sh_lhu_fail;
    set_sh_lhu();
    rf_model[14] = 32'h8012;
    rf_model[16] = 32'h0;
    run_once(0, -1, 1'b0, 32'h0);
    n_checks++; if (o_pass !== 1'b0) begin n_fail++; $display("FAIL fail_pass: got %b expected 0", o_pass); end
    n_checks++; if (o_mis !== 16'd2) begin n_fail++; $display("FAIL fail_count: got %0d expected 2", o_mis); end
    n_checks++; if (o_fv !== 1'b1) begin n_fail++; $display("FAIL fail_valid: got %b expected 1", o_fv); end
    n_checks++; if (o_ffi !== 5'd14) begin n_fail++; $display("FAIL fail_idx: got %0d expected 14", o_ffi); end
    n_checks++; if (o_ffe !== 32'h8002) begin n_fail++; $display("FAIL fail_exp: got %h expected 8002", o_ffe); end
    n_checks++; if (o_ffa !== 32'h8012) begin n_fail++; $display("FAIL fail_act: got %h expected 8012", o_ffa); end
    n_checks++; if (o_pass_late !== 1'b0) begin n_fail++; $display("FAIL fail_held: got %b expected 0", o_pass_late); end
  endtask

  task automatic test_halt;
    int want;
    set_sh_lhu();
    run_once(5, -1, 1'b0, 32'h0);
    n_checks++; if (o_done_cycle != 39) begin n_fail++; $display("FAIL halt_latency: got %0d expected 39", o_done_cycle); end
    n_checks++; if (o_busy != 38) begin n_fail++; $display("FAIL halt_busy_cycles: got %0d expected 38", o_busy); end
    n_checks++; if (idx_log[5] !== 5'd0) begin n_fail++; $display("FAIL halt_idx_before: got %0d expected 0", idx_log[5]); end
    for (int k = 0; k <= NR; k++) begin
      want = (k < NR) ? k : NR - 1;
      n_checks++;
      if (idx_log[6 + k] !== IB'(want)) begin
        n_fail++; $display("FAIL scan_idx_k%0d: got %0d expected %0d", k, idx_log[6 + k], want); end
    end
    n_checks++; if (idx_log[39] !== 5'd0) begin n_fail++; $display("FAIL scan_idx_after: got %0d expected 0", idx_log[39]); end
    n_checks++; if (o_pass !== 1'b1) begin n_fail++; $display("FAIL halt_pass: got %b expected 1", o_pass); end
  endtask

  task automatic test_ignored;
    set_sh_lhu();
    for (int r = 0; r < 2; r++) begin
      run_once(0, (r == 0) ? 10 : 110, 1'b0, 32'h0);
      n_checks++; if (o_dones != 1) begin n_fail++; $display("FAIL ignored_dones_%0d: got %0d expected 1", r, o_dones); end
      n_checks++; if (o_done_cycle != 135) begin n_fail++; $display("FAIL ignored_latency_%0d: got %0d expected 135", r, o_done_cycle); end
      n_checks++; if (o_mis !== 16'h0) begin n_fail++; $display("FAIL ignored_table_%0d: got mis=%0d expected 0", r, o_mis); end
    end
  endtask

  task automatic test_write_with_start;
    logic [DW-1:0] v;
    set_sh_lhu();
    v = $urandom | 32'h1;
    exp_tbl[20] = v;
    rf_model[20] = v;
    run_once(0, -1, 1'b1, v);
    n_checks++; if ({o_pass, o_mis} !== {1'b1, 16'h0}) begin
      n_fail++; $display("FAIL write_with_start: got pass=%b mis=%0d expected 1/0", o_pass, o_mis); end
    n_checks++; if (o_done_cycle != 135) begin n_fail++; $display("FAIL write_with_start_latency: got %0d expected 135", o_done_cycle); end
  endtask

  task automatic test_reset_mid_scan;
    int guard, dones;
    set_sh_lhu();
    rf_model[2] = 32'h55;
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    guard = 0;
    while (!(busy && rf_rd_idx == 5'd10) && guard < 400) begin
      @(negedge clock); guard++;
    end
    n_checks++; if (guard >= 400) begin n_fail++; $display("FAIL midscan_reach_idx10: got timeout expected idx 10"); end
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, pass, mismatch_count, fail_valid, first_fail_idx, first_fail_exp, first_fail_act, rf_rd_idx} !== 96'h0) begin
      n_fail++; $display("FAIL midscan_outputs: got busy=%b fv=%b mis=%0d idx=%0d expected all zero", busy, fail_valid, mismatch_count, rf_rd_idx);
    end
    dones = 0;
    repeat (3) begin @(negedge clock); if (done) dones++; end
    reset = 1'b1;
    repeat (3) begin @(negedge clock); if (done) dones++; end
    n_checks++; if (dones != 0) begin n_fail++; $display("FAIL midscan_no_done: got %0d pulses expected 0", dones); end
    clear_model();
    predict();
    run_once(0, -1, 1'b0, 32'h0);
    n_checks++; if ({o_pass, o_mis} !== {e_pass, CB'(e_mis)}) begin
      n_fail++; $display("FAIL midscan_table_zero: got pass=%b mis=%0d expected %b/%0d", o_pass, o_mis, e_pass, e_mis); end
  endtask

  task automatic test_random;
    int halt_at;
    for (int it = 0; it < 6; it++) begin
      clear_model();
      for (int i = 0; i < NR; i++) begin
        exp_tbl[i] = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
        rf_model[i] = exp_tbl[i];
        if (it != 0 && $urandom_range(0, 5) == 0) rf_model[i] = rf_model[i] ^ (32'h1 << $urandom_range(0, 31));
      end
      halt_at = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 120) : 0;
      load_table();
      predict();
      run_once(halt_at, -1, 1'b0, 32'h0);
      n_checks++; if (o_done_cycle != expected_latency(halt_at)) begin
        n_fail++; $display("FAIL rand%0d_latency: got %0d expected %0d", it, o_done_cycle, expected_latency(halt_at)); end
      n_checks++; if ({o_pass, o_mis, o_fv} !== {e_pass, CB'(e_mis), e_fv}) begin
        n_fail++; $display("FAIL rand%0d_result: got pass=%b mis=%0d fv=%b expected %b/%0d/%b", it, o_pass, o_mis, o_fv, e_pass, e_mis, e_fv); end
      n_checks++; if (e_fv && {o_ffi, o_ffe, o_ffa} !== {IB'(e_ffi), e_ffe, e_ffa}) begin
        n_fail++; $display("FAIL rand%0d_first: got %0d/%h/%h expected %0d/%h/%h", it, o_ffi, o_ffe, o_ffa, e_ffi, e_ffe, e_ffa); end
    end
  endtask

`ifdef REG_CHECK_MASK_EN
  task automatic test_mask;
    clear_model();
    exp_tbl[5] = 32'h1234; mask_tbl[5] = 32'hFF00; rf_model[5] = 32'h12FF;
    load_table();
    run_once(0, -1, 1'b0, 32'h0);
    n_checks++; if (o_pass !== 1'b1) begin n_fail++; $display("FAIL mask_ff00_pass: got %b expected 1", o_pass); end
    mask_tbl[5] = 32'hFFFF;
    load_table();
    run_once(0, -1, 1'b0, 32'h0);
    n_checks++; if ({o_pass, o_ffi, o_ffa} !== {1'b0, 5'd5, 32'h12FF}) begin
      n_fail++; $display("FAIL mask_ffff: got pass=%b idx=%0d act=%h expected 0/5/12ff", o_pass, o_ffi, o_ffa); end
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_sh_lhu_pass();
    test_sh_lhu_fail();
    test_halt();
    test_ignored();
    test_write_with_start();
    test_reset_mid_scan();
    test_random();
`ifdef REG_CHECK_MASK_EN
    test_mask();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
